// File: rtl/instr_encoder.sv
// Instruction encoder: turns mnemonic + operand requests into 32-bit MIPS-style
// words and writes them sequentially into an instruction memory starting at
// BASE_ADDR. The final memory slot is always reserved for a SYSCALL terminator.
module instr_encoder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            op,
   input  logic [4:0]            rs,
   input  logic [4:0]            rt,
   input  logic [4:0]            rd,
   input  logic [15:0]           imm,
   input  logic [25:0]           target,
   input  logic                  finish,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [31:0]         SYSCALL_WORD = 32'h0000_000C;
   localparam logic [DEPTH_LOG2:0] LAST_SLOT    = {1'b0, {DEPTH_LOG2{1'b1}}};
   localparam logic [DEPTH_LOG2:0] COUNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};

   state_t      state;
   logic        fin_pend;   // the word in flight is the terminator
   logic        accept;
   logic        last_slot;
   logic [31:0] word_addr;

   // Mnemonics 12-15 have no encoding.
   function automatic logic op_valid(input logic [3:0] f_op);
      return f_op <= 4'd11;
   endfunction

   // Field packing for every defined mnemonic. JR forces rt/rd to zero;
   // NOOP and SYSCALL ignore all operands.
   function automatic logic [31:0] encode(
      input logic [3:0]  f_op,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [15:0] f_imm,
      input logic [25:0] f_tgt
   );
      logic [31:0] w;
      w = 32'h0;
      case (f_op)
         4'd1:    w = {6'b100011, f_rs, f_rt, f_imm};
         4'd2:    w = {6'b101011, f_rs, f_rt, f_imm};
         4'd3:    w = {6'b000010, f_tgt};
         4'd4:    w = {6'b000011, f_tgt};
         4'd5:    w = {6'b000101, f_rs, f_rt, f_imm};
         4'd6:    w = {6'b001110, f_rs, f_rt, f_imm};
         4'd7:    w = {6'b000000, f_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
         4'd8:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100000};
         4'd9:    w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100010};
         4'd10:   w = {6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b101010};
         4'd11:   w = SYSCALL_WORD;
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   // in_ready is registered and only ever high in IDLE, so it also gates acceptance.
   assign accept    = in_valid & in_ready;
   assign last_slot = (count == LAST_SLOT);
   assign word_addr = BASE_ADDR + ({{(31 - DEPTH_LOG2){1'b0}}, count} << 2);

   // Control FSM with registered handshake, memory-write and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= 32'h0;
         count     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         fin_pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (finish || last_slot) begin
                     // Terminator path: program end or the reserved last slot.
                     mem_wdata <= SYSCALL_WORD;
                     mem_addr  <= word_addr;
                     mem_we    <= 1'b1;
                     in_ready  <= 1'b0;
                     fin_pend  <= 1'b1;
                     state     <= WRITE;
                     if (!finish) err <= 1'b1;
                  end else if (!op_valid(op)) begin
                     // Consumed but not written; stay ready for the next request.
                     err <= 1'b1;
                  end else begin
                     mem_wdata <= encode(op, rs, rt, rd, imm, target);
                     mem_addr  <= word_addr;
                     mem_we    <= 1'b1;
                     in_ready  <= 1'b0;
                     fin_pend  <= 1'b0;
                     state     <= WRITE;
                  end
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               count  <= count + COUNT_ONE;
               if (fin_pend) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  in_ready <= 1'b0;
               end else begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
            end
            DONE: begin
               in_ready <= 1'b0;
               mem_we   <= 1'b0;
               done     <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               mem_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, hand-written corner sequences and a
// randomized run against a behavioural model of the encoder.
module tb_instr_encoder;

   localparam int DL = 2;

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
      logic        fin;
      logic [31:0] exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [4:0]    rs, rt, rd;
   logic [15:0]   imm;
   logic [25:0]   target;
   logic          finish;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [DL:0]   count;
   logic          done;
   logic          err;

   int n_cmp  = 0;
   int n_fail = 0;

   instr_encoder #(.DEPTH_LOG2(DL), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .finish(finish), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .count(count), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural encoder: numeric field weights, decimal opcode/funct values.
   function automatic logic [31:0] ref_encode(input vec_t v);
      int unsigned P26 = 67108864, P21 = 2097152, P16 = 65536, P11 = 2048;
      int unsigned s = v.rs, t = v.rt, d = v.rd, i = v.imm, g = v.target;
      int unsigned r = 0;
      case (v.op)
         4'd1:  r = 35 * P26 + s * P21 + t * P16 + i;
         4'd2:  r = 43 * P26 + s * P21 + t * P16 + i;
         4'd3:  r = 2 * P26 + g;
         4'd4:  r = 3 * P26 + g;
         4'd5:  r = 5 * P26 + s * P21 + t * P16 + i;
         4'd6:  r = 14 * P26 + s * P21 + t * P16 + i;
         4'd7:  r = s * P21 + 8;
         4'd8:  r = s * P21 + t * P16 + d * P11 + 32;
         4'd9:  r = s * P21 + t * P16 + d * P11 + 34;
         4'd10: r = s * P21 + t * P16 + d * P11 + 42;
         4'd11: r = 12;
         default: r = 0;
      endcase
      return r;
   endfunction

   task automatic set_inputs(input vec_t v);
      op = v.op; rs = v.rs; rt = v.rt; rd = v.rd;
      imm = v.imm; target = v.target; finish = v.fin;
   endtask

   // Called at posedge+1; leaves time at posedge+1 with the encoder idle and ready.
   task automatic do_reset(input bit check);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      if (check) begin
         chk("rst_mem_we", 32'(mem_we), 32'h0);
         chk("rst_count", 32'(count), 32'h0);
         chk("rst_err", 32'(err), 32'h0);
         chk("rst_done", 32'(done), 32'h0);
         chk("rst_in_ready", 32'(in_ready), 32'h0);
         chk("rst_mem_addr", mem_addr, 32'h0);
         chk("rst_mem_wdata", mem_wdata, 32'h0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      if (check) chk("ready_after_rst", 32'(in_ready), 32'h1);
   endtask

   // Present one request and hold it until the accepting edge; returns at edge+1.
   task automatic send(input vec_t v);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
         return;
      end
      set_inputs(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // One-cycle in_valid pulse without waiting for in_ready.
   task automatic pulse(input vec_t v);
      set_inputs(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                               input logic [4:0] d, input logic [15:0] i, input logic [25:0] g,
                               input logic f, input logic [31:0] e);
      vec_t v;
      v.op = o; v.rs = s; v.rt = t; v.rd = d; v.imm = i; v.target = g; v.fin = f; v.exp = e;
      return v;
   endfunction

   vec_t tbl[$];
   vec_t v;
   int   m_count;
   bit   m_err, m_done;

   initial begin
      rst_n = 1'b1; in_valid = 1'b0;
      op = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0; finish = 1'b0;

      // Power-on reset: values during reset, in_ready low until the first edge after release.
      #1 rst_n = 1'b0;
      #2;
      chk("por_mem_we", 32'(mem_we), 32'h0);
      chk("por_in_ready", 32'(in_ready), 32'h0);
      chk("por_count", 32'(count), 32'h0);
      chk("por_done", 32'(done), 32'h0);
      chk("por_err", 32'(err), 32'h0);
      chk("por_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1 chk("ready_before_edge", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("ready_first_edge", 32'(in_ready), 32'h1);

      // Encoding table, one word per fresh reset.
      tbl.push_back(mk(4'd8,  5'd1,  5'd2, 5'd3,  16'h0000, 26'h0,       1'b0, 32'h0022_1820));
      tbl.push_back(mk(4'd1,  5'd29, 5'd8, 5'd0,  16'h0004, 26'h0,       1'b0, 32'h8FA8_0004));
      tbl.push_back(mk(4'd3,  5'd0,  5'd0, 5'd0,  16'h0000, 26'h0100000, 1'b0, 32'h0810_0000));
      tbl.push_back(mk(4'd0,  5'd5,  5'd6, 5'd7,  16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h0000_0000));
      tbl.push_back(mk(4'd11, 5'd9,  5'd9, 5'd9,  16'h1234, 26'h1234567, 1'b0, 32'h0000_000C));
      tbl.push_back(mk(4'd7,  5'd31, 5'd5, 5'd9,  16'hABCD, 26'h0,       1'b0, 32'h03E0_0008));
      tbl.push_back(mk(4'd2,  5'd2,  5'd3, 5'd0,  16'h8000, 26'h0,       1'b0, 32'hAC43_8000));
      tbl.push_back(mk(4'd5,  5'd4,  5'd5, 5'd0,  16'hFFFE, 26'h0,       1'b0, 32'h1485_FFFE));
      tbl.push_back(mk(4'd6,  5'd1,  5'd2, 5'd0,  16'h00FF, 26'h0,       1'b0, 32'h3822_00FF));
      tbl.push_back(mk(4'd4,  5'd0,  5'd0, 5'd0,  16'h0000, 26'h3FFFFFF, 1'b0, 32'h0FFF_FFFF));
      tbl.push_back(mk(4'd9,  5'd3,  5'd4, 5'd5,  16'h0000, 26'h0,       1'b0, 32'h0064_2822));
      tbl.push_back(mk(4'd10, 5'd8,  5'd9, 5'd10, 16'h0000, 26'h0,       1'b0, 32'h0109_502A));
      foreach (tbl[k]) begin
         do_reset(1'b0);
         send(tbl[k]);
         chk($sformatf("tbl%0d_we", k), 32'(mem_we), 32'h1);
         chk($sformatf("tbl%0d_word", k), mem_wdata, tbl[k].exp);
         chk($sformatf("tbl%0d_addr", k), mem_addr, 32'h0);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_count", k), 32'(count), 32'h1);
         chk($sformatf("tbl%0d_we_off", k), 32'(mem_we), 32'h0);
      end

      // ADD, LW, J in sequence; words land at 0x0, 0x4, 0x8 and hold after the pulse.
      do_reset(1'b1);
      send(tbl[0]);
      chk("seq_add_we", 32'(mem_we), 32'h1);
      chk("seq_add_addr", mem_addr, 32'h0);
      chk("seq_add_word", mem_wdata, 32'h0022_1820);
      @(posedge clk); #1;
      chk("seq_add_count", 32'(count), 32'h1);
      chk("seq_hold_word", mem_wdata, 32'h0022_1820);
      chk("seq_hold_addr", mem_addr, 32'h0);
      send(tbl[1]);
      chk("seq_lw_addr", mem_addr, 32'h4);
      chk("seq_lw_word", mem_wdata, 32'h8FA8_0004);
      @(posedge clk); #1;
      send(tbl[2]);
      chk("seq_j_addr", mem_addr, 32'h8);
      chk("seq_j_word", mem_wdata, 32'h0810_0000);
      @(posedge clk); #1;
      chk("seq_count3", 32'(count), 32'h3);

      // Invalid op: no write, sticky err, count unchanged, still ready.
      do_reset(1'b0);
      send(mk(4'd13, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 1'b0, 32'h0));
      chk("inv_we", 32'(mem_we), 32'h0);
      chk("inv_err", 32'(err), 32'h1);
      chk("inv_count", 32'(count), 32'h0);
      chk("inv_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("inv_we_later", 32'(mem_we), 32'h0);
      chk("inv_err_sticky", 32'(err), 32'h1);

      // finish with ADD writes SYSCALL, then DONE ignores requests.
      do_reset(1'b0);
      send(mk(4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h0));
      chk("fin_we", 32'(mem_we), 32'h1);
      chk("fin_word", mem_wdata, 32'h0000_000C);
      @(posedge clk); #1;
      chk("fin_done", 32'(done), 32'h1);
      chk("fin_ready", 32'(in_ready), 32'h0);
      chk("fin_err", 32'(err), 32'h0);
      for (int k = 0; k < 3; k++) begin
         pulse(tbl[0]);
         chk($sformatf("fin_nowrite%0d", k), 32'(mem_we), 32'h0);
      end
      chk("fin_count", 32'(count), 32'h1);

      // Fill a 4-word memory with ADDs: last slot becomes SYSCALL and sets err.
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) begin
         send(tbl[0]);
         chk($sformatf("fill%0d_addr", k), mem_addr, 32'(4 * k));
         chk($sformatf("fill%0d_word", k), mem_wdata, (k < 3) ? 32'h0022_1820 : 32'h0000_000C);
         @(posedge clk); #1;
      end
      chk("fill_err", 32'(err), 32'h1);
      chk("fill_done", 32'(done), 32'h1);
      chk("fill_count", 32'(count), 32'h4);
      chk("fill_ready", 32'(in_ready), 32'h0);

      // Reset during WRITE aborts the write and clears everything.
      do_reset(1'b0);
      send(mk(4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0));
      send(tbl[0]);
      @(posedge clk); #1;
      send(tbl[0]);
      chk("abort_pre_we", 32'(mem_we), 32'h1);
      chk("abort_pre_addr", mem_addr, 32'h4);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_we", 32'(mem_we), 32'h0);
      chk("abort_count", 32'(count), 32'h0);
      chk("abort_err", 32'(err), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send(tbl[0]);
      chk("abort_next_addr", mem_addr, 32'h0);
      chk("abort_next_word", mem_wdata, 32'h0022_1820);
      @(posedge clk); #1;
      chk("abort_next_count", 32'(count), 32'h1);

      // Randomized requests against the behavioural model.
      do_reset(1'b0);
      m_count = 0; m_err = 0; m_done = 0;
      for (int it = 0; it < 400; it++) begin
         v.op = 4'($urandom_range(0, 15));
         v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
         v.imm = 16'($urandom); v.target = 26'($urandom);
         v.fin = ($urandom_range(0, 11) == 0);
         v.exp = 32'h0;
         if (m_done) begin
            pulse(v);
            chk("rnd_done_we", 32'(mem_we), 32'h0);
            chk("rnd_done_flag", 32'(done), 32'h1);
            chk("rnd_done_count", 32'(count), 32'(m_count));
            chk("rnd_done_err", 32'(err), 32'(m_err));
            do_reset(1'b0);
            m_count = 0; m_err = 0; m_done = 0;
         end else begin
            send(v);
            if (v.fin || m_count == (1 << DL) - 1) begin
               chk("rnd_sys_we", 32'(mem_we), 32'h1);
               chk("rnd_sys_addr", mem_addr, 32'(4 * m_count));
               chk("rnd_sys_word", mem_wdata, 32'h0000_000C);
               if (!v.fin) m_err = 1;
               m_count++;
               m_done = 1;
               @(posedge clk); #1;
               chk("rnd_sys_done", 32'(done), 32'h1);
               chk("rnd_sys_ready", 32'(in_ready), 32'h0);
            end else if (v.op > 4'd11) begin
               m_err = 1;
               chk("rnd_inv_we", 32'(mem_we), 32'h0);
               chk("rnd_inv_ready", 32'(in_ready), 32'h1);
            end else begin
               chk("rnd_we", 32'(mem_we), 32'h1);
               chk("rnd_addr", mem_addr, 32'(4 * m_count));
               chk("rnd_word", mem_wdata, ref_encode(v));
               m_count++;
               @(posedge clk); #1;
               chk("rnd_ready", 32'(in_ready), 32'h1);
               chk("rnd_done_low", 32'(done), 32'h0);
            end
            chk("rnd_count", 32'(count), 32'(m_count));
            chk("rnd_err", 32'(err), 32'(m_err));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
